dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the CPU datapath's load/store path and the UART program loader. It sequences every access through a small FSM (arbitrate, access, read response) and returns read data with a one-cycle valid pulse. It sits between the `datapath` memory signals (`MemRead`/`MemWrite`, ALU address, `R_data_2`) and the `data_memory` block. The datapath stalls its PC while its request is pending.

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / UART loader) arbiter for the single-port data memory.
// Optional feature: define DMEM_ARB_RR_EN for round-robin conflict resolution (default: CPU priority).
module dmem_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [31:0]       ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
   typedef enum logic {OWN_CPU = 1'b0, OWN_LD = 1'b1} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_owner_q, last_owner_d;
   owner_t            winner;
   logic              any_req;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
   logic              unused_addr_bits;

   // Only the word-address slice reaches memory; byte offset and high bits wrap away.
   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                               ld_addr[31:ADDR_W+2], ld_addr[1:0]};

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      any_req = cpu_req | ld_req;
      if (cpu_req && ld_req) begin
         winner = (last_owner_q == OWN_LD) ? OWN_CPU : OWN_LD;
      end else if (cpu_req) begin
         winner = OWN_CPU;
      end else begin
         winner = OWN_LD;
      end
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner_q;

   always_comb begin
      any_req = cpu_req | ld_req;
      winner  = cpu_req ? OWN_CPU : OWN_LD;
   end
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cpu_rdata_d  = cpu_rdata_q;
      ld_rdata_d   = ld_rdata_q;
      cpu_gnt      = 1'b0;
      ld_gnt       = 1'b0;
      cpu_rvalid   = 1'b0;
      ld_rvalid    = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_ACCESS;
               owner_d = winner;
            end
         end
         S_ACCESS: begin
            mem_en       = 1'b1;
            last_owner_d = owner_q;
            if (owner_q == OWN_CPU) begin
               cpu_gnt   = 1'b1;
               mem_we    = cpu_we;
               mem_addr  = cpu_addr[ADDR_W+1:2];
               mem_wdata = cpu_wdata;
            end else begin
               ld_gnt    = 1'b1;
               mem_we    = ld_we;
               mem_addr  = ld_addr[ADDR_W+1:2];
               mem_wdata = ld_wdata;
            end
            state_d = mem_we ? S_IDLE : S_RESP;
         end
         S_RESP: begin
            // A reset landing on the response cycle abandons the load: no valid pulse.
            if (owner_q == OWN_CPU) begin
               cpu_rvalid  = ~reset;
               cpu_rdata_d = mem_rdata;
            end else begin
               ld_rvalid  = ~reset;
               ld_rdata_d = mem_rdata;
            end
            if (any_req) begin
               state_d = S_ACCESS;
               owner_d = winner;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_LD;
         cpu_rdata_q  <= '0;
         ld_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cpu_rdata_q  <= cpu_rdata_d;
         ld_rdata_q   <= ld_rdata_d;
      end
   end

   // Response data is forwarded in its valid cycle, then held from the register.
   assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign ld_rdata  = ld_rvalid  ? mem_rdata : ld_rdata_q;
   assign cpu_stall = (cpu_req & ~(cpu_gnt & cpu_we)) | cpu_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model and a behavioural RAM.
module tb_dmem_arbiter;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
   logic [31:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              ld_req, ld_we, ld_gnt, ld_rvalid;
   logic [31:0]       ld_addr;
   logic [DATA_W-1:0] ld_wdata, ld_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] ram_q;
   int                errors = 0;
   int                checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Behavioural single-port synchronous RAM standing in for data_memory.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_q <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_q;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic do_reset;
      reset = 1'b1; cpu_req = 1'b0; ld_req = 1'b0;
      tick; tick;
      reset = 1'b0;
   endtask

   // Winner of an arbitration cycle: 1 = loader, 0 = CPU.
   function automatic bit pick(bit c, bit l, bit last_ld);
      if (c && l) return RR ? ~last_ld : 1'b0;
      return l;
   endfunction

   task automatic test_reset;
      tick; settle;
      checks++; if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en, mem_we, cpu_stall} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en, mem_we, cpu_stall}); end
      checks++; if (mem_addr !== 14'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata); end
      checks++; if (cpu_rdata !== 32'd0 || ld_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", cpu_rdata, ld_rdata); end
      cpu_req = 1'b1; ld_req = 1'b1; cpu_we = 1'b1; ld_we = 1'b1;
      cpu_addr = 32'h0; ld_addr = 32'h0; cpu_wdata = 32'h0; ld_wdata = 32'h0;
      tick; settle;
      checks++; if (cpu_gnt !== 1'b0 || ld_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL reset_hold: got gnt=%b%b en=%b expected 000", cpu_gnt, ld_gnt, mem_en); end
      reset = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
      tick; settle;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_idle: got mem_en=%b expected 0", mem_en); end
      $display("reset sequence done");
   endtask

   task automatic test_store;
      tick;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      settle;
      checks++; if (cpu_stall !== 1'b1 || cpu_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL store_c0: got stall=%b gnt=%b en=%b expected 100", cpu_stall, cpu_gnt, mem_en); end
      tick; settle;
      checks++; if (cpu_gnt !== 1'b1 || ld_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL store_gnt: got gnt=%b%b en=%b we=%b expected 1011", cpu_gnt, ld_gnt, mem_en, mem_we); end
      checks++; if (mem_addr !== 14'd4 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_bus: got addr=%h wdata=%h expected 0004/deadbeef", mem_addr, mem_wdata); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL store_stall: got %b expected 0", cpu_stall); end
      tick; cpu_req = 1'b0; settle;
      checks++; if (mem_en !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL store_done: got en=%b gnt=%b expected 00", mem_en, cpu_gnt); end
      $display("cpu store addr=00000010 data=deadbeef");
   endtask

   task automatic test_load;
      tick;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      settle;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_stall0: got %b expected 1", cpu_stall); end
      tick; settle;
      checks++; if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL load_gnt: got gnt=%b en=%b we=%b stall=%b rv=%b expected 11010", cpu_gnt, mem_en, mem_we, cpu_stall, cpu_rvalid); end
      tick; cpu_req = 1'b0; settle;
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_resp: got rv=%b data=%h expected 1/deadbeef", cpu_rvalid, cpu_rdata); end
      tick; settle;
      checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hold: got rv=%b data=%h expected 0/deadbeef", cpu_rvalid, cpu_rdata); end
      $display("cpu load addr=00000010 data=%h", cpu_rdata);
   endtask

   task automatic test_addr_wrap;
      tick;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF0013; cpu_wdata = 32'h0BADC0DE;
      tick; settle;
      checks++; if (cpu_gnt !== 1'b1 || mem_addr !== 14'h0004) begin errors++; $display("FAIL wrap_addr: got gnt=%b addr=%h expected 1/0004", cpu_gnt, mem_addr); end
      tick; cpu_req = 1'b0;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
      tick; settle;
      checks++; if (ld_gnt !== 1'b1 || mem_addr !== 14'h0004) begin errors++; $display("FAIL wrap_ldgnt: got gnt=%b addr=%h expected 1/0004", ld_gnt, mem_addr); end
      tick; ld_req = 1'b0; settle;
      checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h0BADC0DE || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wrap_ldread: got rv=%b data=%h cpu_rv=%b expected 1/0badc0de/0", ld_rvalid, ld_rdata, cpu_rvalid); end
      $display("cpu store addr=ffff0013 -> word 0004, loader read back %h", ld_rdata);
   endtask

   task automatic conflict_pair(input bit ld_first, input logic [31:0] cpu_exp);
      tick;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'h5A5A0001;
      settle;
      checks++; if (cpu_gnt !== 1'b0 || ld_gnt !== 1'b0) begin errors++; $display("FAIL pair_c0: got gnt=%b%b expected 00", cpu_gnt, ld_gnt); end
      tick; settle;
      checks++; if (cpu_gnt !== ~ld_first || ld_gnt !== ld_first) begin errors++; $display("FAIL pair_first: got cpu_gnt=%b ld_gnt=%b expected %b%b", cpu_gnt, ld_gnt, ~ld_first, ld_first); end
      checks++; if (mem_addr !== (ld_first ? 14'd16 : 14'd8)) begin errors++; $display("FAIL pair_addr: got %h expected %h", mem_addr, ld_first ? 14'd16 : 14'd8); end
      if (!ld_first) begin
         tick; cpu_req = 1'b0; settle;
         checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== cpu_exp || ld_gnt !== 1'b0) begin errors++; $display("FAIL pair_resp: got rv=%b data=%h ld_gnt=%b expected 1/%h/0", cpu_rvalid, cpu_rdata, ld_gnt, cpu_exp); end
         tick; settle;
         checks++; if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 14'd16 || mem_wdata !== 32'h5A5A0001) begin errors++; $display("FAIL pair_second: got gnt=%b we=%b addr=%h wd=%h expected 1/1/0010/5a5a0001", ld_gnt, mem_we, mem_addr, mem_wdata); end
         tick; ld_req = 1'b0; settle;
      end else begin
         tick; ld_req = 1'b0; settle;
         checks++; if (cpu_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL pair_idle: got gnt=%b en=%b expected 00", cpu_gnt, mem_en); end
         tick; settle;
         checks++; if (cpu_gnt !== 1'b1 || mem_addr !== 14'd8) begin errors++; $display("FAIL pair_second: got gnt=%b addr=%h expected 1/0008", cpu_gnt, mem_addr); end
         tick; cpu_req = 1'b0; settle;
         checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== cpu_exp) begin errors++; $display("FAIL pair_resp: got rv=%b data=%h expected 1/%h", cpu_rvalid, cpu_rdata, cpu_exp); end
      end
      $display("conflict pair: cpu load 00000020 / loader store 00000040, loader first=%0d", ld_first);
   endtask

   task automatic test_conflict;
      do_reset();
      conflict_pair(1'b0, 32'h0);
      tick;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D;
      tick; tick; cpu_req = 1'b0;
      // The last grant went to the CPU, so round-robin hands the next conflict to the loader.
      conflict_pair(RR, 32'hCAFEF00D);
   endtask

   task automatic test_stream;
      int ld_idx = 0;
      bit p_c = 0, p_l = 0, p_g = 0, last = 1, e_any, win, obs_lg = 0;
      do_reset();
      cpu_we = 1'b0; cpu_addr = 32'h0; ld_we = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         tick;
         if (obs_lg) ld_idx++;
         cpu_req  = (cyc < 30);
         ld_req   = (ld_idx < 8);
         ld_addr  = 32'(32'h100 + ld_idx * 4);
         ld_wdata = 32'(32'hA5000000 + ld_idx);
         settle;
         e_any = (p_c | p_l) & ~p_g;
         win   = pick(p_c, p_l, last);
         checks++; if (cpu_gnt !== (e_any & ~win) || ld_gnt !== (e_any & win)) begin errors++; $display("FAIL stream_gnt cyc=%0d: got cpu=%b ld=%b expected cpu=%b ld=%b", cyc, cpu_gnt, ld_gnt, e_any & ~win, e_any & win); end
         if (e_any) last = win;
         p_c = cpu_req; p_l = ld_req; p_g = e_any; obs_lg = ld_gnt;
      end
      if (obs_lg) ld_idx++;
      checks++; if (ld_idx != 8) begin errors++; $display("FAIL stream_count: got %0d loader writes expected 8 within cycle budget", ld_idx); end
      tick;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h11C; ld_req = 1'b0;
      tick; tick; cpu_req = 1'b0; settle;
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5000007) begin errors++; $display("FAIL stream_readback: got rv=%b data=%h expected 1/a5000007", cpu_rvalid, cpu_rdata); end
      $display("loader stream of 8 stores, last word read back %h", cpu_rdata);
   endtask

   task automatic test_random;
      logic [31:0] refm [16];
      logic [31:0] r, c_pend = 0, l_pend = 0, c_hold = 0, l_hold = 0, e_cd, e_ld;
      logic [3:0]  k;
      bit c_act = 0, l_act = 0, obs_cg = 0, obs_lg = 0;
      bit p_c = 0, p_l = 0, p_g = 0, p_crd = 0, p_lrd = 0, last = 1;
      bit e_any, win, e_cg, e_lg, e_stall;
      for (int i = 0; i < 16; i++) refm[i] = 32'h0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick;
         if (obs_cg) c_act = 0;
         if (obs_lg) l_act = 0;
         if (!c_act && $urandom_range(0, 2) == 0) begin
            r = $urandom; k = 4'($urandom_range(0, 15));
            c_act = 1; cpu_we = r[16]; cpu_wdata = $urandom;
            cpu_addr = {r[31:16], 16'h0800 | {10'd0, k, 2'b00} | {14'd0, r[1:0]}};
         end
         if (!l_act && $urandom_range(0, 2) == 0) begin
            r = $urandom; k = 4'($urandom_range(0, 15));
            l_act = 1; ld_we = r[16]; ld_wdata = $urandom;
            ld_addr = {r[31:16], 16'h0800 | {10'd0, k, 2'b00} | {14'd0, r[1:0]}};
         end
         cpu_req = c_act; ld_req = l_act;
         settle;
         // A pending request in any non-access cycle is granted on the following cycle.
         e_any = (p_c | p_l) & ~p_g;
         win   = pick(p_c, p_l, last);
         e_cg  = e_any & ~win;
         e_lg  = e_any & win;
         e_cd  = p_crd ? c_pend : c_hold;
         e_ld  = p_lrd ? l_pend : l_hold;
         e_stall = (cpu_req & ~(e_cg & cpu_we)) | p_crd;
         checks++; if (cpu_gnt !== e_cg || ld_gnt !== e_lg || mem_en !== e_any) begin errors++; $display("FAIL rnd_gnt cyc=%0d: got cpu=%b ld=%b en=%b expected %b%b%b", cyc, cpu_gnt, ld_gnt, mem_en, e_cg, e_lg, e_any); end
         checks++; if (cpu_rvalid !== p_crd || ld_rvalid !== p_lrd) begin errors++; $display("FAIL rnd_rvalid cyc=%0d: got cpu=%b ld=%b expected %b%b", cyc, cpu_rvalid, ld_rvalid, p_crd, p_lrd); end
         checks++; if (cpu_rdata !== e_cd || ld_rdata !== e_ld) begin errors++; $display("FAIL rnd_rdata cyc=%0d: got cpu=%h ld=%h expected %h %h", cyc, cpu_rdata, ld_rdata, e_cd, e_ld); end
         checks++; if (cpu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d: got %b expected %b", cyc, cpu_stall, e_stall); end
         if (e_cg) begin
            checks++; if (mem_we !== cpu_we || mem_addr !== cpu_addr[15:2] || mem_wdata !== cpu_wdata) begin errors++; $display("FAIL rnd_cpubus cyc=%0d: got we=%b addr=%h wd=%h expected %b %h %h", cyc, mem_we, mem_addr, mem_wdata, cpu_we, cpu_addr[15:2], cpu_wdata); end
            if (cpu_we) refm[cpu_addr[5:2]] = cpu_wdata;
            else        c_pend = refm[cpu_addr[5:2]];
         end else if (e_lg) begin
            checks++; if (mem_we !== ld_we || mem_addr !== ld_addr[15:2] || mem_wdata !== ld_wdata) begin errors++; $display("FAIL rnd_ldbus cyc=%0d: got we=%b addr=%h wd=%h expected %b %h %h", cyc, mem_we, mem_addr, mem_wdata, ld_we, ld_addr[15:2], ld_wdata); end
            if (ld_we) refm[ld_addr[5:2]] = ld_wdata;
            else       l_pend = refm[ld_addr[5:2]];
         end else begin
            checks++; if (mem_we !== 1'b0 || mem_addr !== 14'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rnd_busidle cyc=%0d: got we=%b addr=%h wd=%h expected zeros", cyc, mem_we, mem_addr, mem_wdata); end
         end
         if (p_crd) c_hold = c_pend;
         if (p_lrd) l_hold = l_pend;
         if (e_any) last = win;
         p_c = cpu_req; p_l = ld_req; p_g = e_any;
         p_crd = e_cg & ~cpu_we; p_lrd = e_lg & ~ld_we;
         obs_cg = cpu_gnt; obs_lg = ld_gnt;
      end
      $display("random traffic: 3000 cycles checked");
   endtask

   task automatic test_reset_mid;
      tick; cpu_req = 1'b0; ld_req = 1'b0;
      tick;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      tick; tick; cpu_req = 1'b0; settle;
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rmid_preload: got rv=%b data=%h expected 1/cafef00d", cpu_rvalid, cpu_rdata); end
      tick;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      tick;
      tick; cpu_req = 1'b0; reset = 1'b1; settle;
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_norvalid: got %b expected 0", cpu_rvalid); end
      tick; reset = 1'b0; settle;
      checks++; if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en, mem_we, cpu_stall} !== 7'b0) begin errors++; $display("FAIL rmid_ctrl: got %b expected 0000000", {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en, mem_we, cpu_stall}); end
      checks++; if (cpu_rdata !== 32'd0 || ld_rdata !== 32'd0 || mem_addr !== 14'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rmid_data: got %h %h %h %h expected zeros", cpu_rdata, ld_rdata, mem_addr, mem_wdata); end
      // A store caught in its access cycle by reset still lands in memory.
      tick;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h34; cpu_wdata = 32'h00000077;
      tick; reset = 1'b1; settle;
      checks++; if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL rmid_wissue: got gnt=%b en=%b we=%b expected 111", cpu_gnt, mem_en, mem_we); end
      tick; reset = 1'b0; cpu_req = 1'b0;
      tick;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h34;
      tick; settle;
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rmid_regrant: got %b expected 1", cpu_gnt); end
      tick; cpu_req = 1'b0; settle;
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h00000077) begin errors++; $display("FAIL rmid_committed: got rv=%b data=%h expected 1/00000077", cpu_rvalid, cpu_rdata); end
      $display("reset during load response and during store access done");
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
      ram_q = '0;
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
      test_reset();
      test_store();
      test_load();
      test_addr_wrap();
      test_conflict();
      test_stream();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
